// File: rtl/vram_engine.sv
// VRAM arbiter and block engine for a 40x25 text+color screen: the CPU port has fixed priority,
// the engine performs FILL and (with VRAM_ENGINE_SCROLL_EN defined) one-row SCROLL.
module vram_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_wrdata,
  input  logic        cpu_wren,
  input  logic        cpu_rden,
  output logic [7:0]  cpu_rddata,
  input  logic        cmd,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  fill_text,
  input  logic [7:0]  fill_color,
  output logic        busy,
  output logic        done,
  output logic [10:0] vram_addr,
  output logic [7:0]  vram_wrdata,
  output logic        vram_wren,
  input  logic [7:0]  vram_rddata
);

  localparam logic [9:0] LAST_CELL = 10'd999;
`ifdef VRAM_ENGINE_SCROLL_EN
  localparam logic [9:0] LAST_SRC  = 10'd959;
  localparam logic [9:0] ROW_W     = 10'd40;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1
`ifdef VRAM_ENGINE_SCROLL_EN
    ,
    SC_RD  = 3'd2,
    SC_WR  = 3'd3,
    SC_ROW = 3'd4
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic       plane_q, plane_d;
  logic [7:0] fill_text_q, fill_text_d;
  logic [7:0] fill_color_q, fill_color_d;
  logic       done_q, done_d;
`ifdef VRAM_ENGINE_SCROLL_EN
  logic [7:0] copy_q, copy_d;
  logic       rd_pend_q, rd_pend_d;
`endif

  logic        grant;
  logic        cmd_ok;
  logic [7:0]  fill_byte;
  logic        eng_act;
  logic        eng_wren;
  logic [10:0] eng_addr;
  logic [7:0]  eng_data;

  assign grant      = ~(cpu_wren | cpu_rden);
  assign fill_byte  = plane_q ? fill_color_q : fill_text_q;
  assign busy       = (state_q != IDLE);
  assign cmd_ready  = ~busy;
  assign done       = done_q;
  assign cpu_rddata = vram_rddata;
`ifdef VRAM_ENGINE_SCROLL_EN
  assign cmd_ok = 1'b1;
`else
  assign cmd_ok = ~cmd;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    plane_d      = plane_q;
    fill_text_d  = fill_text_q;
    fill_color_d = fill_color_q;
    done_d       = 1'b0;
    eng_act      = 1'b0;
    eng_wren     = 1'b0;
    eng_addr     = '0;
    eng_data     = '0;
`ifdef VRAM_ENGINE_SCROLL_EN
    rd_pend_d    = 1'b0;
    // Read data lands the cycle after a granted SC_RD whether or not SC_WR is granted,
    // so capture it unconditionally and let the write use the captured value.
    copy_d       = rd_pend_q ? vram_rddata : copy_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ok) begin
          fill_text_d  = fill_text;
          fill_color_d = fill_color;
          cnt_d        = '0;
          plane_d      = 1'b0;
`ifdef VRAM_ENGINE_SCROLL_EN
          state_d      = cmd ? SC_RD : FILL;
`else
          state_d      = FILL;
`endif
        end
      end
      FILL: begin
        eng_act  = 1'b1;
        eng_wren = 1'b1;
        eng_addr = {plane_q, cnt_q};
        eng_data = fill_byte;
        if (grant) begin
          if (cnt_q == LAST_CELL) begin
            cnt_d   = '0;
            plane_d = 1'b1;
            if (plane_q) begin
              plane_d = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
`ifdef VRAM_ENGINE_SCROLL_EN
      SC_RD: begin
        eng_act  = 1'b1;
        eng_addr = {plane_q, cnt_q + ROW_W};
        if (grant) begin
          rd_pend_d = 1'b1;
          state_d   = SC_WR;
        end
      end
      SC_WR: begin
        eng_act  = 1'b1;
        eng_wren = 1'b1;
        eng_addr = {plane_q, cnt_q};
        eng_data = copy_d;
        if (grant) begin
          cnt_d   = cnt_q + 10'd1;
          state_d = (cnt_q == LAST_SRC) ? SC_ROW : SC_RD;
        end
      end
      SC_ROW: begin
        eng_act  = 1'b1;
        eng_wren = 1'b1;
        eng_addr = {plane_q, cnt_q};
        eng_data = fill_byte;
        if (grant) begin
          if (cnt_q == LAST_CELL) begin
            cnt_d   = '0;
            plane_d = 1'b1;
            state_d = SC_RD;
            if (plane_q) begin
              plane_d = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vram_addr   = '0;
    vram_wrdata = '0;
    vram_wren   = 1'b0;
    if (!grant) begin
      vram_addr   = cpu_addr;
      vram_wrdata = cpu_wrdata;
      vram_wren   = cpu_wren;
    end else if (eng_act) begin
      vram_addr   = eng_addr;
      vram_wrdata = eng_data;
      vram_wren   = eng_wren;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      plane_q      <= 1'b0;
      fill_text_q  <= '0;
      fill_color_q <= '0;
      done_q       <= 1'b0;
`ifdef VRAM_ENGINE_SCROLL_EN
      copy_q       <= '0;
      rd_pend_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      plane_q      <= plane_d;
      fill_text_q  <= fill_text_d;
      fill_color_q <= fill_color_d;
      done_q       <= done_d;
`ifdef VRAM_ENGINE_SCROLL_EN
      copy_q       <= copy_d;
      rd_pend_q    <= rd_pend_d;
`endif
    end
  end

endmodule

// File: doc/vram_engine.md
VRAM_ENGINE -- requirements
Module: vram_engine

Interface
REQ-001 SHALL have ports: clk in 1, system clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have CPU ports: cpu_addr in 11, bit10 = plane (0 text, 1 color), bits9:0 = cell; cpu_wrdata in 8; cpu_wren in 1; cpu_rden in 1; cpu_rddata out 8, VRAM read data one cycle after cpu_rden.
REQ-003 SHALL have command ports: cmd in 1 (0 FILL, 1 SCROLL); cmd_valid in 1; cmd_ready out 1; fill_text in 8; fill_color in 8; busy out 1; done out 1, one-cycle pulse.
REQ-004 SHALL have VRAM port: vram_addr out 11; vram_wrdata out 8; vram_wren out 1; vram_rddata in 8, synchronous read with 1-cycle latency.

Function
REQ-005 SHALL give the CPU fixed priority: if cpu_wren or cpu_rden, drive vram_addr/wrdata/wren from the CPU that cycle; engine is not granted and holds its state.
REQ-006 SHALL pass vram_rddata combinationally to cpu_rddata.
REQ-007 SHALL set cmd_ready = ~busy; accept cmd only when cmd_valid && cmd_ready; latch cmd, fill_text, fill_color on accept; ignore cmd_valid while busy.
REQ-008 SHALL assert busy from the cycle after accept until the cycle done pulses, inclusive of the done cycle being busy=0.
REQ-009 SHALL use states IDLE, FILL, SC_RD, SC_WR, SC_ROW.
REQ-010 FILL: IDLE->FILL; per granted cycle write fill_text to text plane cells 0..999, then fill_color to color plane cells 0..999; 2000 granted writes; then IDLE.
REQ-011 SCROLL, per plane (text then color): for n = 0..959, SC_RD issues read of cell n+40 (vram_wren=0), SC_WR writes the captured byte to cell n; then SC_ROW writes the plane's fill byte to cells 960..999.
REQ-012 SHALL capture vram_rddata into a copy register in the cycle immediately after a granted SC_RD; SC_WR writes from that register, so CPU stalls in SC_WR do not corrupt data.
REQ-013 SCROLL totals 3920 granted cycles (1920 reads, 2000 writes).
REQ-014 SHALL advance cell counter (10 bit) and plane bit only on granted cycles; cells 1000..1023 never addressed.
REQ-015 SHALL pulse done for one cycle in the cycle after the final granted write, returning to IDLE in that same cycle.
REQ-016 SHALL drive vram_wren=0 and vram_addr=0 when neither CPU nor a writing/reading engine state is active.
REQ-017 CPU writes during an operation SHALL be performed; coherency with engine contents is not guaranteed.

Reset
REQ-018 On reset: state IDLE, busy=0, done=0, cmd_ready=1, counters and copy register 0, latched fill bytes 0.
REQ-019 Reset mid-operation SHALL abort with no further engine writes from the next cycle; CPU access unaffected.

Configuration
REQ-020 Macro VRAM_ENGINE_SCROLL_EN: defined -> SCROLL supported per REQ-011..013; undefined -> SC_RD/SC_WR/SC_ROW absent, cmd=1 with cmd_valid is ignored (not accepted, busy stays 0, no done), FILL unchanged.

Verification
REQ-021 FILL, fill_text=0x20, fill_color=0x70, no CPU traffic -> 2000 writes, cells 0..999 text=0x20, color=0x70, done at cycle 2001 after accept.
REQ-022 SCROLL on cell n text=n[7:0], color=~n[7:0], fill 0x00/0x07 -> cell n holds old n+40 for n<960, row 24 = 0x00/0x07, done after 3920 granted cycles.
REQ-023 SCROLL with cpu_rden asserted every other cycle -> memory result identical to REQ-022, duration doubles, cpu_rddata correct each read.
REQ-024 cpu_wren held during SC_WR for 5 cycles -> engine stalls 5 cycles, copied byte unchanged, CPU write lands.
REQ-025 Reset asserted at granted write 500 of FILL -> no vram_wren from engine afterwards, busy=0, cmd_ready=1, new FILL accepted next cycle.
REQ-026 Without VRAM_ENGINE_SCROLL_EN, cmd=1 cmd_valid pulse -> busy stays 0, no VRAM writes, no done.
